life_grid_engine: RTL and testbench
===================================

Name: life_grid_engine

Overview:
Parametrised Game-of-Life engine holding a ROWS x COLS cell grid. It generalises the fixed 8x8 tiled array. Adds configurable size, toroidal wrap mode, a free-running mode with a programmable generation rate, a generation counter and stable/extinct detection. It sits between the controller/VGA readout logic and the cell storage, and can be tiled via its edge ports.

Parameters:
ROWS, 8, grid height (>=3).
COLS, 8, grid width (>=3).
WRAP, 0, 0 = edge neighbours come from the edge input ports; 1 = toroidal (edge inputs ignored).
RUN_DIV, 4, clock cycles per generation in run mode (>=1).
GEN_W, 16, generation counter width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low; clears all state.
wr_en  in  1  write one grid row.
wr_row  in  RW=$clog2(ROWS)  row to write; values >=ROWS are ignored.
wr_data  in  COLS  row contents; bit c = cell (row,c).
rd_row  in  RW  row to read.
rd_data  out  COLS  current row contents, combinational; 0 if rd_row>=ROWS.
rd_prev  out  COLS  same row from the previous generation.
step  in  1  single-generation request; honoured only in IDLE.
run  in  1  level; free-run enable.
ni, si  in  COLS  cells north of row 0 / south of row ROWS-1.
wi, ei  in  ROWS  cells west of col 0 / east of col COLS-1.
nwi, nei, swi, sei  in  1  diagonal corner neighbours.
no, so  out  COLS  row 0 / row ROWS-1.
wo, eo  out  ROWS  col 0 / col COLS-1; bit r = row r.
nwo, neo, swo, seo  out  1  cells (0,0), (0,COLS-1), (ROWS-1,0), (ROWS-1,COLS-1).
gen_count  out  GEN_W  generations completed.
gen_tick  out  1  one-cycle pulse after each committed generation.
busy  out  1  FSM not in IDLE.
stable  out  1  last evaluated generation produced no change.
extinct  out  1  grid is all zero (combinational from grid register).

Behaviour:
- Reset (async, while low): grid, prev grid, gen_count, divider, stable and gen_tick are 0; FSM goes to IDLE.
- Coordinates: row 0 is north, col 0 is west.
- Next-state rule (B3/S23): 4-bit neighbour count over 8 neighbours. A dead cell is born at exactly 3; a live cell survives at 2 or 3; all other cells are dead.
- WRAP=0: out-of-grid neighbours come from ni/si/wi/ei/corner inputs.
- WRAP=1: indices wrap modulo ROWS/COLS.
- "Advance" is a single clock edge: prev<=grid, grid<=next, gen_count++ (wraps 2^GEN_W-1 -> 0), gen_tick=1 in the following cycle.
- FSM states:
  - IDLE: step=1 causes an advance (1-cycle latency). If next==grid, stable<=1; otherwise stable<=0. run=1 goes to RUN with divider cleared; run takes priority over step.
  - RUN: divider counts 0..RUN_DIV-1. When it reaches RUN_DIV-1:
    - next!=grid: advance, divider<=0.
    - next==grid: no advance, gen_count unchanged, stable<=1, go to HALT.
    - run=0 at any point: go to IDLE, divider<=0.
    - step is ignored.
  - HALT: grid frozen. run=0 goes to IDLE.
- Write: wr_en with a valid wr_row overwrites that row of the grid at the clock edge.
  - Write and advance in the same cycle: the advance applies first, then the written row overrides its computed value. prev holds the pre-advance grid.
  - A write never changes prev or gen_count, and clears stable.
  - A write in HALT moves the FSM to RUN if run=1.
- Edge and corner outputs reflect the registered grid (no combinational path from edge inputs), so tiling creates no loops.
- busy=1 in RUN and HALT.

Decomposition:
- Package life_pkg holds: FSM state enum (IDLE, RUN, HALT); rule constants BIRTH_CNT=3, SURV_LO=2, SURV_HI=3; the neighbour-count width constant.
- Sub-module life_cell_rule (8 neighbour bits + current state -> next state) is instantiated ROWS*COLS times in a generate loop.
- The top level holds the grid registers, neighbour/edge muxing, FSM, divider and counter.

Test Plan:
1. Blinker, 8x8, WRAP=0: write row3=8'b00011100, pulse step -> rows 2,3,4 = 8'b00001000, rd_prev(row3)=8'b00011100, gen_count=1, gen_tick high for one cycle, stable=0.
2. Block, RUN_DIV=4: write rows 1,2 = 8'b00000110, run=1 -> HALT after 4 cycles, stable=1, gen_count=0, busy=1; drop run -> busy=0 next cycle.
3. Torus, WRAP=1: write row0 bits {7,0,1}, step -> rows 7,0,1 = 8'b00000001, all other rows 0.
4. Edge inputs, WRAP=0, empty grid: ni=8'b00000111, nwi=0, step -> row0=8'b00000010, all other rows 0; no=8'b00000010.
5. Single cell (4,4), step -> extinct=1, gen_count=1. GEN_W=2 variant: 4 steps on a blinker -> gen_count returns to 0.
6. Blinker in RUN with gen_count=5: assert reset mid-divider -> grid, gen_count, busy, stable all 0 immediately (asynchronous); release -> IDLE, step works normally.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game-of-Life grid engine.
package life_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int NBR_CNT_W = 4;

   localparam logic [NBR_CNT_W-1:0] BIRTH_CNT = 4'd3;
   localparam logic [NBR_CNT_W-1:0] SURV_LO   = 4'd2;
   localparam logic [NBR_CNT_W-1:0] SURV_HI   = 4'd3;

endpackage

// File: rtl/life_cell_rule.sv
// B3/S23 next-state rule for a single cell.
module life_cell_rule
   import life_pkg::*;
(
   input  logic [7:0] i_nbr,
   input  logic       i_cur,
   output logic       o_next
);

   logic [NBR_CNT_W-1:0] w_cnt;

   // Population count of the eight neighbours.
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < 8; i++) begin
         w_cnt = w_cnt + NBR_CNT_W'(i_nbr[i]);
      end
   end

   assign o_next = i_cur ? ((w_cnt >= SURV_LO) && (w_cnt <= SURV_HI))
                         : (w_cnt == BIRTH_CNT);

endmodule

// File: rtl/life_grid_engine.sv
// Parametrised Game-of-Life engine: grid storage, neighbour/edge muxing,
// step/run sequencing, generation counter and stable/extinct status.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting; step advances one generation, run starts free-run
// RUN   | free-running, one generation every RUN_DIV cycles
// HALT  | free-run found a still life; grid frozen until run drops
module life_grid_engine
   import life_pkg::*;
#(
   parameter  int ROWS    = 8,
   parameter  int COLS    = 8,
   parameter  int WRAP    = 0,
   parameter  int RUN_DIV = 4,
   parameter  int GEN_W   = 16,
   localparam int RW      = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [RW-1:0]    wr_row,
   input  logic [COLS-1:0]  wr_data,
   input  logic [RW-1:0]    rd_row,
   output logic [COLS-1:0]  rd_data,
   output logic [COLS-1:0]  rd_prev,
   input  logic             step,
   input  logic             run,
   input  logic [COLS-1:0]  ni,
   input  logic [COLS-1:0]  si,
   input  logic [ROWS-1:0]  wi,
   input  logic [ROWS-1:0]  ei,
   input  logic             nwi,
   input  logic             nei,
   input  logic             swi,
   input  logic             sei,
   output logic [COLS-1:0]  no,
   output logic [COLS-1:0]  so,
   output logic [ROWS-1:0]  wo,
   output logic [ROWS-1:0]  eo,
   output logic             nwo,
   output logic             neo,
   output logic             swo,
   output logic             seo,
   output logic [GEN_W-1:0] gen_count,
   output logic             gen_tick,
   output logic             busy,
   output logic             stable,
   output logic             extinct
);

   localparam int               DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
   localparam logic [RW:0]      ROWS_L   = (RW + 1)'(ROWS);

   state_t                      r_state;
   logic [DIV_W-1:0]            r_div;
   logic [GEN_W-1:0]            r_gen;
   logic                        r_tick;
   logic                        r_stable;
   logic [ROWS-1:0][COLS-1:0]   r_grid;
   logic [ROWS-1:0][COLS-1:0]   r_prev;

   logic [ROWS-1:0][COLS-1:0]   w_next;
   logic [ROWS-1:0][COLS-1:0]   w_grid_d;
   logic [ROWS+1:0][COLS+1:0]   w_ext;
   logic                        w_changed;
   logic                        w_adv;
   logic                        w_wr_ok;
   logic                        w_rd_ok;

   // Extended grid: the real cells surrounded by a one-cell halo that comes
   // either from the edge inputs or from the opposite side of the torus.
   for (genvar r = 0; r < ROWS; r++) begin : g_ext_row
      for (genvar c = 0; c < COLS; c++) begin : g_ext_col
         assign w_ext[r+1][c+1] = r_grid[r][c];
      end
   end

   if (WRAP != 0) begin : g_wrap
      logic w_unused_edge;
      assign w_unused_edge = ^{ni, si, wi, ei, nwi, nei, swi, sei};
      for (genvar c = 0; c < COLS; c++) begin : g_ns
         assign w_ext[0][c+1]      = r_grid[ROWS-1][c];
         assign w_ext[ROWS+1][c+1] = r_grid[0][c];
      end
      for (genvar r = 0; r < ROWS; r++) begin : g_we
         assign w_ext[r+1][0]      = r_grid[r][COLS-1];
         assign w_ext[r+1][COLS+1] = r_grid[r][0];
      end
      assign w_ext[0][0]           = r_grid[ROWS-1][COLS-1];
      assign w_ext[0][COLS+1]      = r_grid[ROWS-1][0];
      assign w_ext[ROWS+1][0]      = r_grid[0][COLS-1];
      assign w_ext[ROWS+1][COLS+1] = r_grid[0][0];
   end else begin : g_edge
      for (genvar c = 0; c < COLS; c++) begin : g_ns
         assign w_ext[0][c+1]      = ni[c];
         assign w_ext[ROWS+1][c+1] = si[c];
      end
      for (genvar r = 0; r < ROWS; r++) begin : g_we
         assign w_ext[r+1][0]      = wi[r];
         assign w_ext[r+1][COLS+1] = ei[r];
      end
      assign w_ext[0][0]           = nwi;
      assign w_ext[0][COLS+1]      = nei;
      assign w_ext[ROWS+1][0]      = swi;
      assign w_ext[ROWS+1][COLS+1] = sei;
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_cell_row
      for (genvar c = 0; c < COLS; c++) begin : g_cell_col
         life_cell_rule u_rule (
            .i_nbr  ({w_ext[r][c],   w_ext[r][c+1],   w_ext[r][c+2],
                      w_ext[r+1][c],                  w_ext[r+1][c+2],
                      w_ext[r+2][c], w_ext[r+2][c+1], w_ext[r+2][c+2]}),
            .i_cur  (r_grid[r][c]),
            .o_next (w_next[r][c])
         );
      end
   end

   assign w_changed = (w_next != r_grid);
   assign w_wr_ok   = wr_en && ({1'b0, wr_row} < ROWS_L);
   assign w_rd_ok   = ({1'b0, rd_row} < ROWS_L);
   assign w_adv     = ((r_state == IDLE) && !run && step) ||
                      ((r_state == RUN) && run && (r_div == DIV_LAST) && w_changed);

   // Next grid value: advance first, then a write overrides its row.
   always_comb begin
      w_grid_d = w_adv ? w_next : r_grid;
      if (w_wr_ok) begin
         w_grid_d[wr_row] = wr_data;
      end
   end

   // Grid, history, counter and sequencing FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_div    <= '0;
         r_gen    <= '0;
         r_tick   <= 1'b0;
         r_stable <= 1'b0;
         r_grid   <= '0;
         r_prev   <= '0;
      end else begin
         r_tick <= w_adv;
         r_grid <= w_grid_d;
         if (w_adv) begin
            r_prev <= r_grid;
            r_gen  <= r_gen + 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (run) begin
                  r_state <= RUN;
                  r_div   <= '0;
               end else if (step) begin
                  r_stable <= ~w_changed;
               end
            end
            RUN: begin
               if (!run) begin
                  r_state <= IDLE;
                  r_div   <= '0;
               end else if (r_div == DIV_LAST) begin
                  r_div <= '0;
                  if (w_changed) begin
                     r_stable <= 1'b0;
                  end else begin
                     r_stable <= 1'b1;
                     r_state  <= HALT;
                  end
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            HALT: begin
               if (!run) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
         // A write invalidates the stable verdict and restarts a halted run.
         if (w_wr_ok) begin
            r_stable <= 1'b0;
            if ((r_state == HALT) && run) begin
               r_state <= RUN;
               r_div   <= '0;
            end
         end
      end
   end

   assign rd_data   = w_rd_ok ? r_grid[rd_row] : '0;
   assign rd_prev   = w_rd_ok ? r_prev[rd_row] : '0;

   assign no        = r_grid[0];
   assign so        = r_grid[ROWS-1];
   for (genvar r = 0; r < ROWS; r++) begin : g_side_out
      assign wo[r] = r_grid[r][0];
      assign eo[r] = r_grid[r][COLS-1];
   end
   assign nwo       = r_grid[0][0];
   assign neo       = r_grid[0][COLS-1];
   assign swo       = r_grid[ROWS-1][0];
   assign seo       = r_grid[ROWS-1][COLS-1];

   assign gen_count = r_gen;
   assign gen_tick  = r_tick;
   assign busy      = (r_state != IDLE);
   assign stable    = r_stable;
   assign extinct   = ~|r_grid;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench: instance A is bounded (WRAP=0, GEN_W=16), instance B is a
// torus with a 2-bit generation counter. Both share all stimulus.
`timescale 1ns/1ps
module tb_life_grid_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_row = '0;
   logic [7:0] wr_data = '0;
   logic [2:0] rd_row = '0;
   logic       step = 1'b0;
   logic       run = 1'b0;
   logic [7:0] ni = '0, si = '0, wi = '0, ei = '0;
   logic       nwi = 1'b0, nei = 1'b0, swi = 1'b0, sei = 1'b0;

   logic [7:0]  a_rd_data, a_rd_prev, a_no, a_so, a_wo, a_eo;
   logic        a_nwo, a_neo, a_swo, a_seo, a_tick, a_busy, a_stable, a_extinct;
   logic [15:0] a_gen;
   logic [7:0]  b_rd_data, b_rd_prev, b_no, b_so, b_wo, b_eo;
   logic        b_nwo, b_neo, b_swo, b_seo, b_tick, b_busy, b_stable, b_extinct;
   logic [1:0]  b_gen;

   int n_checks = 0;
   int n_fail   = 0;

   always #50 clk = ~clk;

   life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(0), .RUN_DIV(4), .GEN_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
      .rd_row(rd_row), .rd_data(a_rd_data), .rd_prev(a_rd_prev), .step(step), .run(run),
      .ni(ni), .si(si), .wi(wi), .ei(ei), .nwi(nwi), .nei(nei), .swi(swi), .sei(sei),
      .no(a_no), .so(a_so), .wo(a_wo), .eo(a_eo),
      .nwo(a_nwo), .neo(a_neo), .swo(a_swo), .seo(a_seo),
      .gen_count(a_gen), .gen_tick(a_tick), .busy(a_busy), .stable(a_stable),
      .extinct(a_extinct)
   );

   life_grid_engine #(.ROWS(8), .COLS(8), .WRAP(1), .RUN_DIV(4), .GEN_W(2)) u_dut_b (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
      .rd_row(rd_row), .rd_data(b_rd_data), .rd_prev(b_rd_prev), .step(step), .run(run),
      .ni(ni), .si(si), .wi(wi), .ei(ei), .nwi(nwi), .nei(nei), .swi(swi), .sei(sei),
      .no(b_no), .so(b_so), .wo(b_wo), .eo(b_eo),
      .nwo(b_nwo), .neo(b_neo), .swo(b_swo), .seo(b_seo),
      .gen_count(b_gen), .gen_tick(b_tick), .busy(b_busy), .stable(b_stable),
      .extinct(b_extinct)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_row(input logic [2:0] r, input logic [7:0] d);
      wr_en = 1'b1; wr_row = r; wr_data = d;
      cyc(1);
      wr_en = 1'b0;
   endtask

   task automatic do_step();
      step = 1'b1;
      cyc(1);
      step = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(1);
   endtask

   // exp[r] is the expected content of row r; sel_b picks instance B.
   task automatic check_grid(input string tag, input bit sel_b, input bit prev,
                             input logic [7:0][7:0] exp);
      logic [7:0] got;
      for (int r = 0; r < 8; r++) begin
         rd_row = 3'(r);
         #1;
         if (sel_b) got = prev ? b_rd_prev : b_rd_data;
         else       got = prev ? a_rd_prev : a_rd_data;
         check($sformatf("%s row%0d", tag, r), {24'd0, got}, {24'd0, exp[r]});
      end
   endtask

   localparam logic [7:0][7:0] G_ZERO  = '0;
   localparam logic [7:0][7:0] G_HORIZ = {8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00};
   localparam logic [7:0][7:0] G_VERT  = {8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
   localparam logic [7:0][7:0] G_VWR   = {8'h00, 8'h01, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
   localparam logic [7:0][7:0] G_BLOCK = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'h06, 8'h00};
   localparam logic [7:0][7:0] G_TORUS = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
   localparam logic [7:0][7:0] G_EDGE  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};

   initial begin
      // Reset state
      cyc(2);
      check("rst gen", {16'd0, a_gen}, 32'd0);
      check("rst busy", {31'd0, a_busy}, 32'd0);
      check("rst stable", {31'd0, a_stable}, 32'd0);
      check("rst tick", {31'd0, a_tick}, 32'd0);
      check("rst extinct", {31'd0, a_extinct}, 32'd1);
      check_grid("rst grid", 1'b0, 1'b0, G_ZERO);
      reset = 1'b1;
      cyc(1);

      // Blinker, single step
      write_row(3'd3, 8'b00011100);
      check("wr extinct", {31'd0, a_extinct}, 32'd0);
      do_step();
      check("blk tick", {31'd0, a_tick}, 32'd1);
      check("blk gen", {16'd0, a_gen}, 32'd1);
      check("blk stable", {31'd0, a_stable}, 32'd0);
      check_grid("blk grid", 1'b0, 1'b0, G_VERT);
      check_grid("blk prev", 1'b0, 1'b1, G_HORIZ);
      cyc(1);
      check("blk tick low", {31'd0, a_tick}, 32'd0);
      check("blk busy", {31'd0, a_busy}, 32'd0);

      // Keep stepping: blinker period 2, B counter wraps at 4
      do_step();
      check_grid("blk2 grid", 1'b0, 1'b0, G_HORIZ);
      do_step();
      check("bgen 3", {30'd0, b_gen}, 32'd3);
      do_step();
      check("bgen wrap", {30'd0, b_gen}, 32'd0);
      check("agen 4", {16'd0, a_gen}, 32'd4);
      check_grid("btorus blk", 1'b1, 1'b0, G_HORIZ);

      // Write and advance in the same cycle
      do_reset();
      write_row(3'd3, 8'b00011100);
      step = 1'b1; wr_en = 1'b1; wr_row = 3'd6; wr_data = 8'h01;
      cyc(1);
      step = 1'b0; wr_en = 1'b0;
      check("wadv gen", {16'd0, a_gen}, 32'd1);
      check("wadv stable", {31'd0, a_stable}, 32'd0);
      check_grid("wadv grid", 1'b0, 1'b0, G_VWR);
      check_grid("wadv prev", 1'b0, 1'b1, G_HORIZ);

      // Single cell dies; second step on empty grid is stable
      do_reset();
      write_row(3'd4, 8'b00010000);
      do_step();
      check("one extinct", {31'd0, a_extinct}, 32'd1);
      check("one gen", {16'd0, a_gen}, 32'd1);
      check("one stable0", {31'd0, a_stable}, 32'd0);
      do_step();
      check("empty gen", {16'd0, a_gen}, 32'd2);
      check("empty stable", {31'd0, a_stable}, 32'd1);
      write_row(3'd0, 8'h00);
      check("wr clr stable", {31'd0, a_stable}, 32'd0);
      check("wr keeps gen", {16'd0, a_gen}, 32'd2);

      // Block in run mode halts after one divider period
      do_reset();
      write_row(3'd1, 8'b00000110);
      write_row(3'd2, 8'b00000110);
      run = 1'b1;
      cyc(1);
      check("run busy", {31'd0, a_busy}, 32'd1);
      cyc(3);
      check("run pre halt", {31'd0, a_stable}, 32'd0);
      cyc(1);
      check("halt stable", {31'd0, a_stable}, 32'd1);
      check("halt busy", {31'd0, a_busy}, 32'd1);
      check("halt gen", {16'd0, a_gen}, 32'd0);
      check("halt tick", {31'd0, a_tick}, 32'd0);
      check_grid("halt grid", 1'b0, 1'b0, G_BLOCK);
      // Write in HALT with run high restarts the divider
      write_row(3'd5, 8'h00);
      check("halt wr stable", {31'd0, a_stable}, 32'd0);
      cyc(3);
      check("rerun pre", {31'd0, a_stable}, 32'd0);
      cyc(1);
      check("rerun halt", {31'd0, a_stable}, 32'd1);
      run = 1'b0;
      cyc(1);
      check("idle busy", {31'd0, a_busy}, 32'd0);

      // Torus wrap across row 0 / col 0
      do_reset();
      write_row(3'd0, 8'b10000011);
      do_step();
      check_grid("torus grid", 1'b1, 1'b0, G_TORUS);
      check("torus wo", {24'd0, b_wo}, 32'h83);
      check("torus eo", {24'd0, b_eo}, 32'h00);
      check("torus nwo", {31'd0, b_nwo}, 32'd1);
      check("torus swo", {31'd0, b_swo}, 32'd1);
      check("torus gen", {30'd0, b_gen}, 32'd1);

      // North edge input births a cell in row 0 of A; B ignores it
      do_reset();
      ni = 8'b00000111;
      do_step();
      ni = 8'h00;
      check_grid("edge grid", 1'b0, 1'b0, G_EDGE);
      check("edge no", {24'd0, a_no}, 32'h02);
      check("edge so", {24'd0, a_so}, 32'h00);
      check("edge b extinct", {31'd0, b_extinct}, 32'd1);

      // Asynchronous reset mid-run
      do_reset();
      write_row(3'd3, 8'b00011100);
      repeat (5) do_step();
      check("pre gen 5", {16'd0, a_gen}, 32'd5);
      run = 1'b1;
      cyc(2);
      check("pre busy", {31'd0, a_busy}, 32'd1);
      #20;
      reset = 1'b0;
      run   = 1'b0;
      #1;
      check("async gen", {16'd0, a_gen}, 32'd0);
      check("async busy", {31'd0, a_busy}, 32'd0);
      check("async stable", {31'd0, a_stable}, 32'd0);
      check_grid("async grid", 1'b0, 1'b0, G_ZERO);
      cyc(1);
      reset = 1'b1;
      cyc(1);
      write_row(3'd3, 8'b00011100);
      do_step();
      check("post gen", {16'd0, a_gen}, 32'd1);
      check_grid("post grid", 1'b0, 1'b0, G_VERT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
